// File: rtl/pixel_frame_sequencer.sv
// Frame sequencer for the pixel array: ERASE -> EXPOSE -> CONVERT -> READ -> DONE,
// with outputs registered from the next state. Optional macro FRAME_COUNT_EN adds FRAME_COUNT.
module pixel_frame_sequencer #(
  parameter int BIT_DEPTH    = 8,
  parameter int HEIGHT       = 2,
  parameter int ERASE_CYCLES = 5,
  parameter int EXP_W        = 16
) (
  input  logic                 SYSTEM_CLK,
  input  logic                 RESET_N,
  input  logic                 START,
  input  logic                 ABORT,
  input  logic                 CONTINUOUS,
  input  logic [EXP_W-1:0]     EXPOSE_TIME,
  output logic                 POWER_ENABLE,
  output logic                 ERASE,
  output logic                 EXPOSE,
  output logic                 CONVERT,
  output logic                 WRITE_ENABLE,
  output logic                 COUNTER_RESET,
  output logic [BIT_DEPTH-1:0] RAMP_CODE,
  output logic                 READ_RESET,
  output logic                 READ_CLK,
  output logic                 BUSY,
  output logic                 FRAME_DONE
`ifdef FRAME_COUNT_EN
  ,
  output logic [15:0]          FRAME_COUNT
`endif
);

  // The shared phase counter must hold the last index of the longest state.
  localparam int CW_CONV  = BIT_DEPTH + 1;
  localparam int CW_READ  = $clog2(2 * HEIGHT + 1) + 1;
  localparam int CW_ERASE = $clog2(ERASE_CYCLES) + 1;
  localparam int CW_A     = (EXP_W > CW_CONV) ? EXP_W : CW_CONV;
  localparam int CW_B     = (CW_READ > CW_ERASE) ? CW_READ : CW_ERASE;
  localparam int CW       = (CW_A > CW_B) ? CW_A : CW_B;

  localparam logic [CW-1:0] ERASE_LAST = CW'(ERASE_CYCLES - 1);
  localparam logic [CW-1:0] CONV_LAST  = CW'((2 ** BIT_DEPTH) - 1);
  localparam logic [CW-1:0] READ_LAST  = CW'(2 * HEIGHT);

  typedef enum logic [2:0] {
    S_IDLE, S_ERASE, S_EXPOSE, S_CONVERT, S_READ, S_DONE
  } state_t;

  state_t            r_state;
  logic [CW-1:0]     r_cnt;
  logic [EXP_W-1:0]  r_exp_time;

  state_t            w_next_state;
  logic [CW-1:0]     w_next_cnt;
  logic              w_latch_exp;
  logic [EXP_W-1:0]  w_exp_last;

  always_comb begin
    // NOTE: every w_* gets a default first so no path leaves one unassigned and no latch is inferred.
    w_next_state = r_state;
    w_next_cnt   = r_cnt + CW'(1);
    w_latch_exp  = 1'b0;
    w_exp_last   = (r_exp_time == '0) ? '0 : r_exp_time - EXP_W'(1);

    case (r_state)
      S_IDLE: begin
        w_next_cnt = '0;
        if (START && !ABORT) begin
          w_next_state = S_ERASE;
          w_latch_exp  = 1'b1;
        end
      end
      S_ERASE: if (r_cnt == ERASE_LAST) begin
        w_next_state = S_EXPOSE;
        w_next_cnt   = '0;
      end
      S_EXPOSE: if (r_cnt == CW'(w_exp_last)) begin
        w_next_state = S_CONVERT;
        w_next_cnt   = '0;
      end
      S_CONVERT: if (r_cnt == CONV_LAST) begin
        w_next_state = S_READ;
        w_next_cnt   = '0;
      end
      S_READ: if (r_cnt == READ_LAST) begin
        w_next_state = S_DONE;
        w_next_cnt   = '0;
      end
      S_DONE: begin
        w_next_cnt = '0;
        if (CONTINUOUS) begin
          w_next_state = S_ERASE;
          w_latch_exp  = 1'b1;
        end else begin
          w_next_state = S_IDLE;
        end
      end
      default: begin
        w_next_state = S_IDLE;
        w_next_cnt   = '0;
      end
    endcase

    // Abort overrides every transition, including the DONE -> ERASE restart.
    if (ABORT && (r_state != S_IDLE)) begin
      w_next_state = S_IDLE;
      w_next_cnt   = '0;
      w_latch_exp  = 1'b0;
    end
  end

  always_ff @(posedge SYSTEM_CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      r_state       <= S_IDLE;
      r_cnt         <= '0;
      r_exp_time    <= '0;
      POWER_ENABLE  <= 1'b0;
      ERASE         <= 1'b0;
      EXPOSE        <= 1'b0;
      CONVERT       <= 1'b0;
      WRITE_ENABLE  <= 1'b0;
      COUNTER_RESET <= 1'b0;
      RAMP_CODE     <= '0;
      READ_RESET    <= 1'b0;
      READ_CLK      <= 1'b0;
      BUSY          <= 1'b0;
      FRAME_DONE    <= 1'b0;
`ifdef FRAME_COUNT_EN
      FRAME_COUNT   <= '0;
`endif
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values regardless of statement order.
      r_state       <= w_next_state;
      r_cnt         <= w_next_cnt;
      if (w_latch_exp) r_exp_time <= EXPOSE_TIME;
      POWER_ENABLE  <= (w_next_state == S_EXPOSE) || (w_next_state == S_CONVERT) ||
                       (w_next_state == S_READ);
      ERASE         <= (w_next_state == S_ERASE);
      EXPOSE        <= (w_next_state == S_EXPOSE);
      CONVERT       <= (w_next_state == S_CONVERT);
      WRITE_ENABLE  <= (w_next_state == S_EXPOSE) || (w_next_state == S_CONVERT);
      COUNTER_RESET <= (w_next_state == S_ERASE) && (w_next_cnt == '0);
      RAMP_CODE     <= (w_next_state == S_CONVERT) ? w_next_cnt[BIT_DEPTH-1:0] : '0;
      READ_RESET    <= (w_next_state == S_READ) && (w_next_cnt == '0);
      READ_CLK      <= (w_next_state == S_READ) && w_next_cnt[0];
      BUSY          <= (w_next_state != S_IDLE);
      FRAME_DONE    <= (w_next_state == S_DONE);
`ifdef FRAME_COUNT_EN
      if (w_next_state == S_DONE) FRAME_COUNT <= FRAME_COUNT + 16'd1;
`endif
    end
  end

endmodule
